// File: rtl/rsa_proto_pkg.sv
// Shared definitions for the RSA command/BRAM protocol: command codes,
// operand indices and the host sequencer state encoding.
package rsa_proto_pkg;

   localparam logic [31:0] CMD_X         = 32'd0;
   localparam logic [31:0] CMD_E         = 32'd1;
   localparam logic [31:0] CMD_M         = 32'd2;
   localparam logic [31:0] CMD_R2M       = 32'd3;
   localparam logic [31:0] CMD_RM        = 32'd4;
   localparam logic [31:0] CMD_EXP_START = 32'd5;
   localparam logic [31:0] CMD_WRITE     = 32'd6;

   localparam logic [2:0] OP_X   = 3'd0;
   localparam logic [2:0] OP_E   = 3'd1;
   localparam logic [2:0] OP_M   = 3'd2;
   localparam logic [2:0] OP_R2M = 3'd3;
   localparam logic [2:0] OP_RM  = 3'd4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CMD,
      ST_DATA,
      ST_ACKW,
      ST_DRAIN,
      ST_RDWAIT,
      ST_RDSKIP,
      ST_OUT
   } seq_state_t;

   // Which part of the job the shared CMD/ACKW/DRAIN steps are serving.
   typedef enum logic [1:0] {
      PH_LOAD,
      PH_EXP,
      PH_WR
   } seq_phase_t;

   function automatic logic [2:0] lowest_set(input logic [4:0] mask);
      lowest_set = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (mask[i]) lowest_set = 3'(i);
      end
   endfunction

endpackage

// File: rtl/rsa_host_sequencer_if.sv
// Command/BRAM/done channel between the host sequencer (master) and the
// exponentiation wrapper (slave).
interface rsa_host_sequencer_if #(
   parameter int DW = 512
) ();

   logic [31:0]   port1_dout;
   logic          port1_valid;
   logic          port1_read;
   logic [DW-1:0] bram_din1;
   logic [DW-1:0] bram_din2;
   logic          bram_din_valid;
   logic [DW-1:0] bram_dout1;
   logic [DW-1:0] bram_dout2;
   logic          bram_dout1_valid;
   logic          bram_dout2_valid;
   logic          bram_dout_read;
   logic          port2_valid;
   logic          port2_read;

   modport master (
      output port1_dout, port1_valid, bram_din1, bram_din2, bram_din_valid,
             bram_dout_read, port2_read,
      input  port1_read, bram_dout1, bram_dout2, bram_dout1_valid,
             bram_dout2_valid, port2_valid
   );

   modport slave (
      input  port1_dout, port1_valid, bram_din1, bram_din2, bram_din_valid,
             bram_dout_read, port2_read,
      output port1_read, bram_dout1, bram_dout2, bram_dout1_valid,
             bram_dout2_valid, port2_valid
   );

endinterface

// File: rtl/rsa_timeout_ctr.sv
// Cycle counter for bounded waits; i_clr marks the first cycle of a new wait
// so that cycle counts as zero.
module rsa_timeout_ctr #(
   parameter logic [31:0] TIMEOUT = 32'd4000000
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   logic [31:0] r_cnt;
   logic [31:0] w_cnt_eff;

   assign w_cnt_eff = i_clr ? 32'd0 : r_cnt;
   assign o_expired = i_en && (w_cnt_eff >= TIMEOUT - 32'd1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt <= 32'd0;
      end else if (i_en) begin
         r_cnt <= w_cnt_eff + 32'd1;
      end else begin
         r_cnt <= 32'd0;
      end
   end

endmodule

// File: rtl/rsa_host_sequencer.sv
// Host-side job sequencer: loads selected operands into the RSA wrapper,
// starts exponentiation, reads back the result pair and hands it on.
module rsa_host_sequencer
   import rsa_proto_pkg::*;
#(
   parameter int          DW      = 512,
   parameter logic [31:0] TIMEOUT = 32'd4000000
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [4:0]    load_mask,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          op_req,
   output logic [2:0]    op_sel,
   input  logic          op_valid,
   input  logic [DW-1:0] op_din1,
   input  logic [DW-1:0] op_din2,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_dout1,
   output logic [DW-1:0] res_dout2,
   rsa_host_sequencer_if.master wr
);

   seq_state_t    r_state, r_prev;
   seq_phase_t    r_phase;
   logic [4:0]    r_mask;
   logic          r_busy, r_done, r_error;
   logic          r_op_req;
   logic [2:0]    r_op_sel;
   logic          r_res_valid;
   logic [DW-1:0] r_res_dout1, r_res_dout2;
   logic [31:0]   r_port1_dout;
   logic          r_port1_valid;
   logic [DW-1:0] r_bram_din1, r_bram_din2;
   logic          r_bram_din_valid;
   logic          r_bram_dout_read;
   logic          r_port2_read;

   logic          w_wait, w_tmr_clr, w_expired;
   logic [2:0]    w_start_idx, w_next_idx;

   assign w_wait = (r_state == ST_CMD) || (r_state == ST_ACKW) ||
                   (r_state == ST_DRAIN) || (r_state == ST_RDWAIT);
   assign w_tmr_clr   = (r_state != r_prev);
   assign w_start_idx = lowest_set(load_mask);
   assign w_next_idx  = lowest_set(r_mask);

   rsa_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
      .clk       (clk),
      .resetn    (resetn),
      .i_clr     (w_tmr_clr),
      .i_en      (w_wait),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state          <= ST_IDLE;
         r_prev           <= ST_IDLE;
         r_phase          <= PH_LOAD;
         r_mask           <= 5'd0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_error          <= 1'b0;
         r_op_req         <= 1'b0;
         r_op_sel         <= 3'd0;
         r_res_valid      <= 1'b0;
         r_res_dout1      <= '0;
         r_res_dout2      <= '0;
         r_port1_dout     <= 32'd0;
         r_port1_valid    <= 1'b0;
         r_bram_din1      <= '0;
         r_bram_din2      <= '0;
         r_bram_din_valid <= 1'b0;
         r_bram_dout_read <= 1'b0;
         r_port2_read     <= 1'b0;
      end else begin
         r_prev           <= r_state;
         r_done           <= 1'b0;
         r_bram_din_valid <= 1'b0;
         r_bram_dout_read <= 1'b0;
         r_port2_read     <= 1'b0;
         if (w_expired) begin
            r_error       <= 1'b1;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_port1_valid <= 1'b0;
            r_op_req      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_state       <= ST_IDLE;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_error <= 1'b0;
                     r_busy  <= 1'b1;
                     if (load_mask != 5'd0) begin
                        r_mask   <= load_mask & ~(5'd1 << w_start_idx);
                        r_phase  <= PH_LOAD;
                        r_op_sel <= w_start_idx;
                        r_op_req <= 1'b1;
                        r_state  <= ST_FETCH;
                     end else begin
                        r_mask        <= 5'd0;
                        r_phase       <= PH_EXP;
                        r_port1_dout  <= CMD_EXP_START;
                        r_port1_valid <= 1'b1;
                        r_state       <= ST_CMD;
                     end
                  end
               end
               ST_FETCH: begin
                  if (op_valid) begin
                     r_bram_din1   <= op_din1;
                     r_bram_din2   <= op_din2;
                     r_op_req      <= 1'b0;
                     r_port1_dout  <= 32'(r_op_sel);
                     r_port1_valid <= 1'b1;
                     r_state       <= ST_CMD;
                  end
               end
               ST_CMD: begin
                  if (wr.port1_read) begin
                     r_port1_valid <= 1'b0;
                     unique case (r_phase)
                        PH_LOAD: begin
                           r_bram_din_valid <= 1'b1;
                           r_state          <= ST_DATA;
                        end
                        PH_EXP:  r_state <= ST_ACKW;
                        default: r_state <= ST_RDWAIT;
                     endcase
                  end
               end
               ST_DATA: r_state <= ST_ACKW;
               ST_ACKW: begin
                  if (wr.port2_valid) begin
                     r_port2_read <= 1'b1;
                     r_state      <= ST_DRAIN;
                  end
               end
               // The wrapper's done flag lingers a cycle after the ack.
               ST_DRAIN: begin
                  if (!wr.port2_valid) begin
                     unique case (r_phase)
                        PH_LOAD: begin
                           if (r_mask != 5'd0) begin
                              r_mask   <= r_mask & ~(5'd1 << w_next_idx);
                              r_op_sel <= w_next_idx;
                              r_op_req <= 1'b1;
                              r_state  <= ST_FETCH;
                           end else begin
                              r_phase       <= PH_EXP;
                              r_port1_dout  <= CMD_EXP_START;
                              r_port1_valid <= 1'b1;
                              r_state       <= ST_CMD;
                           end
                        end
                        PH_EXP: begin
                           r_phase       <= PH_WR;
                           r_port1_dout  <= CMD_WRITE;
                           r_port1_valid <= 1'b1;
                           r_state       <= ST_CMD;
                        end
                        default: begin
                           r_res_valid <= 1'b1;
                           r_state     <= ST_OUT;
                        end
                     endcase
                  end
               end
               ST_RDWAIT: begin
                  if (wr.bram_dout1_valid && wr.bram_dout2_valid) begin
                     r_res_dout1      <= wr.bram_dout1;
                     r_res_dout2      <= wr.bram_dout2;
                     r_bram_dout_read <= 1'b1;
                     r_state          <= ST_RDSKIP;
                  end
               end
               ST_RDSKIP: r_state <= ST_ACKW;
               ST_OUT: begin
                  if (res_ready) begin
                     r_res_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy              = r_busy;
   assign done              = r_done;
   assign error             = r_error;
   assign op_req            = r_op_req;
   assign op_sel            = r_op_sel;
   assign res_valid         = r_res_valid;
   assign res_dout1         = r_res_dout1;
   assign res_dout2         = r_res_dout2;
   assign wr.port1_dout     = r_port1_dout;
   assign wr.port1_valid    = r_port1_valid;
   assign wr.bram_din1      = r_bram_din1;
   assign wr.bram_din2      = r_bram_din2;
   assign wr.bram_din_valid = r_bram_din_valid;
   assign wr.bram_dout_read = r_bram_dout_read;
   assign wr.port2_read     = r_port2_read;

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Bench for rsa_host_sequencer: behavioural wrapper stub, operand source,
// directed vector table, randomized jobs, timeout and reset corner cases.
module tb_rsa_host_sequencer;

   localparam int          DW  = 32;
   localparam logic [31:0] TMO = 32'd100;

   logic          clk = 1'b0;
   logic          resetn, start, op_valid, res_ready;
   logic [4:0]    load_mask;
   logic          busy, done, error, op_req, res_valid;
   logic [2:0]    op_sel;
   logic [DW-1:0] op_din1, op_din2, res_dout1, res_dout2;

   rsa_host_sequencer_if #(.DW(DW)) wif ();

   rsa_host_sequencer #(.DW(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .resetn(resetn), .start(start), .load_mask(load_mask),
      .busy(busy), .done(done), .error(error), .op_req(op_req),
      .op_sel(op_sel), .op_valid(op_valid), .op_din1(op_din1),
      .op_din2(op_din2), .res_valid(res_valid), .res_ready(res_ready),
      .res_dout1(res_dout1), .res_dout2(res_dout2), .wr(wif)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0, cyc_read = 0, done_cnt = 0, p2r_cnt = 0;
   int rd_delay = 0, p2_hold = 1;
   bit never_done = 1'b0;
   int cmd_q[$];
   logic [DW-1:0] src1[5], src2[5], model1[5], model2[5];
   logic [DW-1:0] wreg1[5], wreg2[5];
   logic [DW-1:0] sres1 = '0, sres2 = '0;

   typedef struct {
      logic [4:0] mask;
      int x1, e1, m1, x2, e2, m2;
      int rd, hold, rdy;
      int exp1, exp2;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] modexp(input logic [DW-1:0] b, input logic [DW-1:0] e,
                                            input logic [DW-1:0] m);
      longint r;
      if (m == 0) return '0;
      r = 1 % longint'(m);
      for (longint i = 0; i < longint'(e); i++) r = (r * longint'(b)) % longint'(m);
      return DW'(r);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      #3;
      if (done) done_cnt++;
      if (wif.port2_read) p2r_cnt++;
   end

   // Operand source: answers op_req after a short random delay.
   initial begin
      int opw;
      opw = 0; op_valid = 1'b0; op_din1 = '0; op_din2 = '0;
      forever begin
         @(negedge clk);
         #1;
         if (op_valid) op_valid = 1'b0;
         else if (op_req && resetn) begin
            if (opw > 0) opw--;
            else begin
               op_din1  = src1[op_sel];
               op_din2  = src2[op_sel];
               op_valid = 1'b1;
               opw      = int'($urandom_range(0, 2));
            end
         end
      end
   end

   task automatic stub_step(output bit ab);
      @(negedge clk);
      #2;
      ab = !resetn;
   endtask

   // Behavioural wrapper: stores operands, computes plain X^E mod M per core.
   initial begin
      bit ab;
      int cmd, n;
      for (int i = 0; i < 5; i++) begin wreg1[i] = '0; wreg2[i] = '0; end
      wif.port1_read = 0; wif.port2_valid = 0; wif.bram_dout1 = '0; wif.bram_dout2 = '0;
      wif.bram_dout1_valid = 0; wif.bram_dout2_valid = 0;
      cmd = 0;
      forever begin
         stub_step(ab);
         if (!ab && wif.port1_valid) begin
            for (int i = 0; i < rd_delay && !ab; i++) stub_step(ab);
            if (!ab) begin
               cmd = int'(wif.port1_dout);
               wif.port1_read = 1'b1;
               cmd_q.push_back(cmd);
               cyc_read = cyc;
               stub_step(ab);
               wif.port1_read = 1'b0;
            end
            if (!ab) begin
               chk("p1_once", wif.port1_valid, 0);
               if (cmd <= 4) begin
                  chk("din_strobe", wif.bram_din_valid, 1);
                  wreg1[cmd] = wif.bram_din1;
                  wreg2[cmd] = wif.bram_din2;
               end else if (cmd == 5) begin
                  sres1 = modexp(wreg1[0], wreg1[1], wreg1[2]);
                  sres2 = modexp(wreg2[0], wreg2[1], wreg2[2]);
               end else if (cmd == 6) begin
                  wif.bram_dout1 = sres1; wif.bram_dout2 = sres2;
                  wif.bram_dout1_valid = 1'b1;
                  stub_step(ab);
                  if (!ab) chk("dout_both", wif.bram_dout_read, 0);
                  wif.bram_dout2_valid = 1'b1;
                  n = 0;
                  while (!ab && !wif.bram_dout_read && n < 50) begin stub_step(ab); n++; end
                  if (!ab) chk("dout_read_seen", wif.bram_dout_read, 1);
                  wif.bram_dout1_valid = 1'b0; wif.bram_dout2_valid = 1'b0;
               end
            end
            if (!ab && !(cmd == 5 && never_done)) begin
               n = int'($urandom_range(1, 4));
               for (int i = 0; i < n && !ab; i++) stub_step(ab);
               if (!ab) begin
                  wif.port2_valid = 1'b1;
                  n = 0;
                  while (!ab && !wif.port2_read && n < 200) begin stub_step(ab); n++; end
                  if (!ab) chk("p2_read_seen", wif.port2_read, 1);
                  for (int i = 1; i < p2_hold && !ab; i++) stub_step(ab);
                  wif.port2_valid = 1'b0;
               end
            end
         end
         if (ab) begin
            wif.port1_read = 0; wif.port2_valid = 0;
            wif.bram_dout1_valid = 0; wif.bram_dout2_valid = 0;
         end
      end
   end

   task automatic model_load(input logic [4:0] mask);
      for (int i = 0; i < 5; i++) if (mask[i]) begin model1[i] = src1[i]; model2[i] = src2[i]; end
   endtask

   task automatic run_job(input logic [4:0] mask, input int rd, input int hold, input int rdy,
                          input logic [DW-1:0] exp1, input logic [DW-1:0] exp2);
      int exp_cmds[$];
      int d0, p0, n;
      bit stable, seq_ok;
      logic [DW-1:0] c1, c2;
      for (int i = 0; i < 5; i++) if (mask[i]) exp_cmds.push_back(i);
      exp_cmds.push_back(5);
      exp_cmds.push_back(6);
      rd_delay = rd; p2_hold = hold;
      cmd_q.delete();
      d0 = done_cnt; p0 = p2r_cnt;
      @(negedge clk); start = 1'b1; load_mask = mask;
      @(negedge clk); start = 1'b0;
      chk("busy_set", busy, 1);
      chk("err_clr", error, 0);
      n = 0;
      while (!res_valid && n < 3000) begin @(negedge clk); n++; end
      chk("res_valid_wait", res_valid, 1);
      if (!res_valid) return;
      c1 = res_dout1; c2 = res_dout2; stable = 1'b1;
      repeat (rdy) begin
         @(negedge clk);
         if (!res_valid || res_dout1 !== c1 || res_dout2 !== c2) stable = 1'b0;
      end
      if (rdy > 0) chk("res_stable", stable, 1);
      chk("res1", res_dout1, exp1);
      chk("res2", res_dout2, exp2);
      res_ready = 1'b1;
      @(negedge clk); res_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("busy_clr", busy, 0);
      chk("res_valid_clr", res_valid, 0);
      @(negedge clk);
      chk("done_once", done, 0);
      #5;
      seq_ok = (cmd_q.size() == exp_cmds.size());
      if (seq_ok) foreach (exp_cmds[i]) if (cmd_q[i] != exp_cmds[i]) seq_ok = 1'b0;
      chk("ncmd", cmd_q.size(), exp_cmds.size());
      chk("cmd_seq", seq_ok, 1);
      chk("p2_reads", p2r_cnt - p0, exp_cmds.size());
      chk("done_cnt", done_cnt - d0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d0;
      logic [4:0] m;
      vecs[0] = '{5'h1F, 2, 3, 7, 5, 3, 13, 0, 1, 0, 1, 8};
      vecs[1] = '{5'h01, 3, 0, 0, 4, 0, 0, 0, 1, 0, 6, 12};
      vecs[2] = '{5'h06, 0, 2, 5, 0, 2, 11, 10, 2, 0, 4, 5};
      vecs[3] = '{5'h00, 0, 0, 0, 0, 0, 0, 1, 1, 20, 4, 5};
      for (int i = 0; i < 5; i++) begin
         src1[i] = '0; src2[i] = '0; model1[i] = '0; model2[i] = '0;
      end
      resetn = 1'b0; start = 1'b0; load_mask = 5'd0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_op_req", op_req, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_dout", {res_dout1, res_dout2}, 0);
      chk("rst_strobes", {wif.port1_valid, wif.bram_din_valid, wif.bram_dout_read, wif.port2_read}, 0);
      resetn = 1'b1;
      @(negedge clk);

      foreach (vecs[v]) begin
         src1[0] = DW'(vecs[v].x1); src1[1] = DW'(vecs[v].e1); src1[2] = DW'(vecs[v].m1);
         src2[0] = DW'(vecs[v].x2); src2[1] = DW'(vecs[v].e2); src2[2] = DW'(vecs[v].m2);
         src1[3] = DW'(vecs[v].x1 + 20); src1[4] = DW'(vecs[v].x1 + 30);
         src2[3] = DW'(vecs[v].x2 + 40); src2[4] = DW'(vecs[v].x2 + 50);
         model_load(vecs[v].mask);
         run_job(vecs[v].mask, vecs[v].rd, vecs[v].hold, vecs[v].rdy,
                 DW'(vecs[v].exp1), DW'(vecs[v].exp2));
      end

      // Exponentiation never completes: abort after exactly TMO cycles.
      never_done = 1'b1; rd_delay = 0;
      @(negedge clk); start = 1'b1; load_mask = 5'h00;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!done && n < 300) begin @(negedge clk); n++; end
      chk("to_done", done, 1);
      chk("to_latency", cyc - cyc_read, 101);
      chk("to_error", error, 1);
      chk("to_busy", busy, 0);
      chk("to_strobes", {wif.port1_valid, wif.port2_read, wif.bram_din_valid,
                         wif.bram_dout_read, op_req, res_valid}, 0);
      never_done = 1'b0;
      @(negedge clk);
      chk("to_err_sticky", error, 1);
      run_job(5'h00, 0, 1, 0, modexp(model1[0], model1[1], model1[2]),
              modexp(model2[0], model2[1], model2[2]));

      // Reset in the middle of a data strobe, then a clean job.
      for (int i = 0; i < 5; i++) begin
         src1[i] = DW'($urandom_range(2, 40)); src2[i] = DW'($urandom_range(2, 40));
      end
      rd_delay = 0; p2_hold = 1; d0 = done_cnt;
      @(negedge clk); start = 1'b1; load_mask = 5'h1F;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!wif.bram_din_valid && n < 100) begin @(negedge clk); n++; end
      chk("rst_reach_data", wif.bram_din_valid, 1);
      resetn = 1'b0;
      @(negedge clk);
      chk("rst_mid_strobes", {wif.port1_valid, wif.bram_din_valid, wif.bram_dout_read,
                              wif.port2_read, op_req, res_valid, busy, done}, 0);
      @(negedge clk);
      resetn = 1'b1;
      #5;
      chk("rst_no_done", done_cnt - d0, 0);
      model_load(5'h1F);
      run_job(5'h1F, 0, 1, 0, modexp(model1[0], model1[1], model1[2]),
              modexp(model2[0], model2[1], model2[2]));

      // Randomized jobs against the operand-store model.
      for (int j = 0; j < 8; j++) begin
         m = 5'($urandom_range(0, 31));
         src1[0] = DW'($urandom_range(0, 60)); src2[0] = DW'($urandom_range(0, 60));
         src1[1] = DW'($urandom_range(0, 6));  src2[1] = DW'($urandom_range(0, 6));
         src1[2] = DW'($urandom_range(2, 60)); src2[2] = DW'($urandom_range(2, 60));
         src1[3] = DW'($urandom); src2[3] = DW'($urandom);
         src1[4] = DW'($urandom); src2[4] = DW'($urandom);
         model_load(m);
         run_job(m, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)),
                 int'($urandom_range(0, 3)), modexp(model1[0], model1[1], model1[2]),
                 modexp(model2[0], model2[1], model2[2]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
